// File: rtl/apb_reg_subordinate.sv
// apb_reg_subordinate: APB completer with a strobed register bank, wait states and error reporting.
module apb_reg_subordinate #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int RegNum = 8,
  parameter int WaitStates = 0,
  parameter logic [RegNum-1:0] PrivMask = '0
) (
  input  logic                          clk,
  input  logic                          nReset,
  input  logic [AddrWidth-1:0]          addr,
  input  logic [3:0]                    prot,
  input  logic                          select,
  input  logic                          enable,
  input  logic                          write,
  input  logic [DataWidth-1:0]          wData,
  input  logic [DataWidth/8-1:0]        strb,
  output logic                          ready,
  output logic [DataWidth-1:0]          rData,
  output logic                          subError,
  output logic [RegNum*DataWidth-1:0]   regsOut
);
  localparam int B = DataWidth / 8;
  localparam int S = $clog2(B);
  localparam int IW = RegNum > 1 ? $clog2(RegNum) : 1;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic [IW-1:0] idx_q, idx_d, idx_cap;
  logic [DataWidth-1:0] rdat_q, rdat_d;
  logic [DataWidth-1:0] regs [RegNum];
  logic [AddrWidth-1:0] word;
  logic in_range, bad, commit;
  logic unused_prot;
  assign unused_prot = ^prot[3:1];
  assign word = addr >> S;
  assign idx_cap = word[IW-1:0];
  // word index bounds the byte address exactly, so misaligned tails need no extra range term
  assign in_range = word < AddrWidth'(RegNum);
  assign bad = ((addr & AddrWidth'(B - 1)) != '0) || !in_range || (PrivMask[idx_cap] && !prot[0]);
  assign ready = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign subError = ready && err_q;
  assign rData = ready ? rdat_q : '0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    err_d = err_q;
    idx_d = idx_q;
    rdat_d = rdat_q;
    commit = 1'b0;
    if (state_q == IDLE) begin
      if (select && !enable) begin
        state_d = ACCESS;
        cnt_d = 4'(WaitStates);
        err_d = bad;
        idx_d = idx_cap;
        rdat_d = bad ? '0 : regs[idx_cap];
      end
    end else if (!select) begin
      state_d = IDLE;
    end else if (cnt_q == 4'd0) begin
      state_d = IDLE;
      commit = write && !err_q;
    end else if (enable) begin
      cnt_d = cnt_q - 4'd1;
    end
  end
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      err_q <= 1'b0;
      idx_q <= '0;
      rdat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      idx_q <= idx_d;
      rdat_q <= rdat_d;
    end
  end
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < RegNum; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < RegNum; i++)
        for (int k = 0; k < B; k++)
          if (idx_q == IW'(i) && strb[k]) regs[i][8*k +: 8] <= wData[8*k +: 8];
    end
  end
  for (genvar i = 0; i < RegNum; i++) begin : g_out
    assign regsOut[i*DataWidth +: DataWidth] = regs[i];
  end
endmodule

// File: tb/tb_apb_reg_subordinate.sv
// tb_apb_reg_subordinate: directed checks of three completers with 0, 2 and 3 wait states.
module tb_apb_reg_subordinate;
  logic clk = 1'b0;
  logic nReset = 1'b0;
  logic [31:0] addr, wData;
  logic [3:0] prot, strb;
  logic enable, write;
  logic [2:0] sel, rdy, serr;
  logic [2:0][31:0] rd;
  logic [2:0][255:0] ro;
  logic [255:0] snap;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_reg_subordinate #(
      .AddrWidth(32), .DataWidth(32), .RegNum(8),
      .WaitStates(g == 0 ? 0 : g == 1 ? 2 : 3), .PrivMask(8'h01)
    ) u_dut (
      .clk(clk), .nReset(nReset), .addr(addr), .prot(prot), .select(sel[g]),
      .enable(enable), .write(write), .wData(wData), .strb(strb),
      .ready(rdy[g]), .rData(rd[g]), .subError(serr[g]), .regsOut(ro[g])
    );
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // called on a falling edge; returns on the falling edge of the first idle cycle
  task automatic xfer(input int u, input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input logic p, input logic exp_err,
                      input logic [31:0] exp_rd, input int exp_wait);
    int k = 0;
    addr = a; write = w; wData = d; strb = s; prot = {3'b000, p}; sel[u] = 1'b1; enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    while (k < 20 && !rdy[u]) begin
      check("rdata_before_ready", 64'(rd[u]), 64'd0);
      @(negedge clk);
      k++;
    end
    check("wait_cycles", 64'(k), 64'(exp_wait));
    check("suberror", 64'(serr[u]), 64'(exp_err));
    if (!w && !exp_err) check("rdata", 64'(rd[u]), 64'(exp_rd));
    @(negedge clk);
    sel[u] = 1'b0; enable = 1'b0;
  endtask
  initial begin
    addr = '0; wData = '0; prot = '0; strb = '0; enable = 1'b0; write = 1'b0; sel = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(rdy), 64'd0);
    check("reset_suberror", 64'(serr), 64'd0);
    check("reset_regs", 64'(|ro), 64'd0);
    nReset = 1'b1;
    @(negedge clk);
    xfer(2, 32'h8, 1'b1, 32'h5A5A_A5A5, 4'hF, 1'b0, 1'b0, 32'h0, 3);
    check("ws3_write", 64'(ro[2][95:64]), 64'h5A5A_A5A5);
    xfer(2, 32'h8, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h5A5A_A5A5, 3);
    addr = 32'h8; write = 1'b1; wData = 32'hFFFF_FFFF; strb = 4'hF; prot = '0; sel[2] = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    nReset = 1'b0;
    #1;
    check("midreset_ready", 64'(rdy[2]), 64'd0);
    check("midreset_rdata", 64'(rd[2]), 64'd0);
    check("midreset_regs", 64'(|ro), 64'd0);
    sel = '0; enable = 1'b0;
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
    xfer(2, 32'h8, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 3);
    xfer(0, 32'h8, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0, 0);
    check("ws0_write", 64'(ro[0][95:64]), 64'hDEAD_BEEF);
    xfer(0, 32'h8, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'hDEAD_BEEF, 0);
    xfer(0, 32'h4, 1'b1, 32'h1122_3344, 4'hF, 1'b0, 1'b0, 32'h0, 0);
    xfer(0, 32'h4, 1'b1, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b0, 32'h0, 0);
    check("partial_strobe", 64'(ro[0][63:32]), 64'h11BB_33DD);
    xfer(0, 32'h4, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h11BB_33DD, 0);
    snap = ro[0];
    xfer(0, 32'h5, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 32'h0, 0);
    xfer(0, 32'h21, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 32'h0, 0);
    xfer(0, 32'h20, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 32'h0, 0);
    xfer(0, 32'h0, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 32'h0, 0);
    check("error_no_write", 64'(ro[0] != snap), 64'd0);
    xfer(0, 32'h0, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, 32'h0, 0);
    xfer(0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'hCAFE_F00D, 0);
    xfer(0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 0);
    xfer(1, 32'hC, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 32'h0, 2);
    addr = 32'hC; write = 1'b1; wData = 32'hFFFF_FFFF; strb = 4'hF; prot = '0; sel[1] = 1'b1; enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    check("abort_ready_t1", 64'(rdy[1]), 64'd0);
    @(negedge clk);
    check("abort_ready_t2", 64'(rdy[1]), 64'd0);
    sel[1] = 1'b0; enable = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_ready_after", 64'(rdy[1]), 64'd0);
    end
    check("abort_no_write", 64'(ro[1][127:96]), 64'h1234_5678);
    xfer(1, 32'hC, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h1234_5678, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
